// File: rtl/audio_pkg.sv
// audio_pkg: register map, FIFOSPACE field layout and feeder FSM states shared by audio blocks
package audio_pkg;
    localparam logic [1:0] ADDR_CTRL      = 2'd0;
    localparam logic [1:0] ADDR_FIFOSPACE = 2'd1;
    localparam logic [1:0] ADDR_LEFTDATA  = 2'd2;
    localparam logic [1:0] ADDR_RIGHTDATA = 2'd3;
    localparam int FS_WSLC_LSB = 24;
    localparam int FS_WSRC_LSB = 16;
    localparam int FS_W        = 8;
    typedef enum logic [2:0] {IDLE, POLL_RD, POLL_WAIT, WR_L, WR_R, GAP} feeder_state_e;
    // Writable space is limited by whichever channel FIFO in the core is fuller.
    function automatic logic [FS_W-1:0] credit_min(input logic [31:0] space);
        logic [FS_W-1:0] l;
        logic [FS_W-1:0] r;
        l = space[FS_WSLC_LSB +: FS_W];
        r = space[FS_WSRC_LSB +: FS_W];
        return (l < r) ? l : r;
    endfunction
endpackage

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: synchronous first-word-fall-through FIFO with registered occupancy count
module audio_sample_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_wdata,
    output logic [W-1:0]             o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;
    assign o_count = r_count;
    assign o_full  = r_count == CW'(DEPTH);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && r_count != '0;
    assign o_rdata = r_mem[r_rp];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop)  r_rp <= r_rp + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= i_wdata;
    end
endmodule

// File: rtl/audio_dac_feeder.sv
// audio_dac_feeder: buffers stereo pairs and streams them into the audio core as FIFOSPACE credit allows
module audio_dac_feeder
    import audio_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int POLL_GAP   = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          snk_valid,
    output logic                          snk_ready,
    input  logic [31:0]                   snk_left,
    input  logic [31:0]                   snk_right,
    output logic [1:0]                    av_address,
    output logic                          av_chipselect,
    output logic                          av_read,
    output logic                          av_write,
    output logic [31:0]                   av_writedata,
    input  logic [31:0]                   av_readdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   underrun_cnt
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int GW = $clog2(POLL_GAP) + 1;
    feeder_state_e r_state;
    feeder_state_e w_next;
    logic [7:0]    r_credit;
    logic [7:0]    w_credit_dec;
    logic [GW-1:0] r_gap;
    logic          r_ready_en;
    logic          r_cs;
    logic          r_rd;
    logic          r_wr;
    logic [15:0]   r_under;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [63:0]   w_head;
    logic [LW-1:0] w_level;
    logic [LW-1:0] w_level_after;

    audio_sample_fifo #(.DEPTH(FIFO_DEPTH), .W(64)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({snk_left, snk_right}),
        .o_rdata (w_head),
        .o_count (w_level),
        .o_full  (w_full)
    );

    assign snk_ready     = r_ready_en && !w_full;
    assign w_push        = snk_valid && snk_ready;
    assign w_pop         = r_state == WR_R;
    assign w_credit_dec  = r_credit - 8'd1;
    // Occupancy as it will be after this edge, counting a concurrent push.
    assign w_level_after = w_level - LW'(1) + LW'(w_push);
    assign fifo_level    = w_level;
    assign underrun_cnt  = r_under;
    assign av_chipselect = r_cs;
    assign av_read       = r_rd;
    assign av_write      = r_wr;
    assign av_address    = r_state == POLL_RD ? ADDR_FIFOSPACE :
                           r_state == WR_L    ? ADDR_LEFTDATA  :
                           r_state == WR_R    ? ADDR_RIGHTDATA : ADDR_CTRL;
    assign av_writedata  = r_state == WR_L ? w_head[63:32] :
                           r_state == WR_R ? w_head[31:0]  : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (enable && w_level != '0) w_next = POLL_RD;
            POLL_RD:   w_next = POLL_WAIT;
            POLL_WAIT: w_next = credit_min(av_readdata) == 8'd0 ? GAP : WR_L;
            WR_L:      w_next = WR_R;
            WR_R:      w_next = (enable && w_credit_dec != 8'd0 && w_level_after != '0) ? WR_L : IDLE;
            GAP:       if (r_gap == GW'(POLL_GAP - 1)) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ready_en <= 1'b0;
            r_cs       <= 1'b0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_credit   <= '0;
            r_gap      <= '0;
            r_under    <= '0;
        end else begin
            r_ready_en <= 1'b1;
            r_cs       <= w_next == POLL_RD || w_next == WR_L || w_next == WR_R;
            r_rd       <= w_next == POLL_RD;
            r_wr       <= w_next == WR_L || w_next == WR_R;
            r_credit   <= r_state == POLL_WAIT ? credit_min(av_readdata) :
                          r_state == WR_R      ? w_credit_dec : r_credit;
            r_gap      <= r_state == GAP ? r_gap + GW'(1) : '0;
            if (r_state == WR_R && w_credit_dec != 8'd0 && w_level_after == '0 && r_under != 16'hFFFF)
                r_under <= r_under + 16'd1;
        end
    end
endmodule

// File: tb/tb_audio_dac_feeder.sv
// tb_audio_dac_feeder: directed checks of polling, credit-limited writes, gap timing, backpressure and reset
module tb_audio_dac_feeder;
    localparam int FIFO_DEPTH = 16;
    localparam int POLL_GAP   = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        enable = 1'b0;
    logic        snk_valid = 1'b0;
    logic        snk_ready;
    logic [31:0] snk_left = '0;
    logic [31:0] snk_right = '0;
    logic [1:0]  av_address;
    logic        av_chipselect;
    logic        av_read;
    logic        av_write;
    logic [31:0] av_writedata;
    logic [31:0] av_readdata = '0;
    logic [4:0]  fifo_level;
    logic [15:0] underrun_cnt;

    logic [31:0] space = '0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [33:0] wq[$];
    int          rq[$];

    audio_dac_feeder #(.FIFO_DEPTH(FIFO_DEPTH), .POLL_GAP(POLL_GAP)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .snk_valid     (snk_valid),
        .snk_ready     (snk_ready),
        .snk_left      (snk_left),
        .snk_right     (snk_right),
        .av_address    (av_address),
        .av_chipselect (av_chipselect),
        .av_read       (av_read),
        .av_write      (av_write),
        .av_writedata  (av_writedata),
        .av_readdata   (av_readdata),
        .fifo_level    (fifo_level),
        .underrun_cnt  (underrun_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        av_readdata <= av_read ? space : 32'h0;
        if (av_write) wq.push_back({av_address, av_writedata});
        if (av_read)  rq.push_back(cyc);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] l, input logic [31:0] r);
        snk_valid = 1'b1;
        snk_left  = l;
        snk_right = r;
        step();
        snk_valid = 1'b0;
    endtask

    task automatic wait_wq(input int n, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            ok = wq.size() >= n;
        end
        check(tag, 64'(ok), 64'(1));
    endtask

    task automatic wait_rq(input int n, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            ok = rq.size() >= n;
        end
        check(tag, 64'(ok), 64'(1));
    endtask

    task automatic wait_wr(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            ok = av_write;
        end
        check(tag, 64'(ok), 64'(1));
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #2;
        check("rst_ready", 64'(snk_ready), 64'(0));
        check("rst_level", 64'(fifo_level), 64'(0));
        check("rst_strobes", 64'({av_chipselect, av_read, av_write}), 64'(0));
        check("rst_addr_data", 64'({av_address, av_writedata}), 64'(0));
        check("rst_underrun", 64'(underrun_cnt), 64'(0));
        step();
        step();
        reset_n = 1'b1;
        check("ready_pre_edge", 64'(snk_ready), 64'(0));
        step();
        check("ready_post_edge", 64'(snk_ready), 64'(1));

        // Latency: push into empty FIFO with enable high, credit 1
        enable = 1'b1;
        space  = 32'h0101_0000;
        push(32'h1111_0000, 32'h2222_0000);
        step();
        check("lat_rd", 64'({av_chipselect, av_read, av_write, av_address}), 64'({3'b110, 2'd1}));
        step();
        check("lat_wait", 64'(av_write), 64'(0));
        step();
        check("lat_wr_l", 64'({av_write, av_address, av_writedata}), 64'({1'b1, 2'd2, 32'h1111_0000}));
        step();
        check("lat_wr_r", 64'({av_write, av_address, av_writedata}), 64'({1'b1, 2'd3, 32'h2222_0000}));
        step();
        check("lat_idle", 64'({av_chipselect, fifo_level, underrun_cnt}), 64'(0));
        enable = 1'b0;
        wq.delete();
        rq.delete();

        // Credit 2 with three pairs buffered
        push(32'hA000_0000, 32'hB000_0000);
        push(32'hA000_0001, 32'hB000_0001);
        push(32'hA000_0002, 32'hB000_0002);
        check("c2_level3", 64'(fifo_level), 64'(3));
        space  = 32'h0202_0000;
        enable = 1'b1;
        wait_wq(4, "c2_timeout");
        enable = 1'b0;
        check("c2_w0", 64'(wq[0]), 64'({2'd2, 32'hA000_0000}));
        check("c2_w1", 64'(wq[1]), 64'({2'd3, 32'hB000_0000}));
        check("c2_w2", 64'(wq[2]), 64'({2'd2, 32'hA000_0001}));
        check("c2_w3", 64'(wq[3]), 64'({2'd3, 32'hB000_0001}));
        check("c2_idle", 64'({av_chipselect, av_write, fifo_level}), 64'({2'b00, 5'd1}));
        step();
        check("c2_count", 64'(wq.size()), 64'(4));
        wq.delete();
        rq.delete();

        // Zero credit: gap between polls
        space  = 32'h0000_0000;
        enable = 1'b1;
        wait_rq(2, "gap_timeout");
        enable = 1'b0;
        check("gap_spacing", 64'(rq[1] - rq[0]), 64'(POLL_GAP + 3));
        repeat (12) step();
        check("gap_no_write", 64'(wq.size()), 64'(0));
        check("gap_level", 64'(fifo_level), 64'(1));
        wq.delete();
        rq.delete();

        // Underrun: one pair, generous credit
        space  = 32'h4040_0000;
        enable = 1'b1;
        wait_wq(2, "ur_timeout");
        enable = 1'b0;
        check("ur_w0", 64'(wq[0]), 64'({2'd2, 32'hA000_0002}));
        check("ur_w1", 64'(wq[1]), 64'({2'd3, 32'hB000_0002}));
        check("ur_cnt", 64'(underrun_cnt), 64'(1));
        check("ur_level", 64'(fifo_level), 64'(0));
        repeat (3) step();
        check("ur_count", 64'(wq.size()), 64'(2));
        wq.delete();
        rq.delete();

        // Fill with enable low
        for (int i = 0; i < 16; i++) push(32'h1000_0000 + i, 32'h2000_0000 + i);
        check("full_level", 64'(fifo_level), 64'(16));
        check("full_ready", 64'(snk_ready), 64'(0));
        push(32'hDEAD_BEEF, 32'hDEAD_BEEF);
        check("full_17th", 64'(fifo_level), 64'(16));
        check("full_no_poll", 64'(rq.size()), 64'(0));

        // Enable dropped during WR_L
        space  = 32'h0505_0000;
        enable = 1'b1;
        wait_wr("en_timeout");
        enable = 1'b0;
        check("en_wr_l", 64'({av_address, av_writedata}), 64'({2'd2, 32'h1000_0000}));
        step();
        check("en_wr_r", 64'({av_write, av_address, av_writedata}), 64'({1'b1, 2'd3, 32'h2000_0000}));
        step();
        check("en_idle", 64'({av_chipselect, av_write, av_read}), 64'(0));
        repeat (10) step();
        check("en_writes", 64'(wq.size()), 64'(2));
        check("en_reads", 64'(rq.size()), 64'(1));
        check("en_level", 64'({fifo_level, underrun_cnt}), 64'({5'd15, 16'd1}));

        // Reset mid WR_L
        space  = 32'h0303_0000;
        enable = 1'b1;
        wait_wr("rs_timeout");
        #2 reset_n = 1'b0;
        #1;
        check("rs_strobes", 64'({av_chipselect, av_read, av_write}), 64'(0));
        check("rs_level", 64'(fifo_level), 64'(0));
        check("rs_underrun", 64'(underrun_cnt), 64'(0));
        check("rs_ready", 64'(snk_ready), 64'(0));
        check("rs_addr_data", 64'({av_address, av_writedata}), 64'(0));
        step();
        reset_n = 1'b1;
        step();
        check("rs_ready_back", 64'({snk_ready, av_write, fifo_level}), 64'({2'b10, 5'd0}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/audio_dac_feeder.md
AUDIO_DAC_FEEDER -- requirements
Module: audio_dac_feeder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, stereo sample pairs buffered (power of two, 4..64).
REQ-002 SHALL have parameter POLL_GAP, default 8, idle cycles between a zero-space poll and the next poll.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port enable  in  1  permits polling and writes to the audio core.
REQ-006 SHALL have port snk_valid  in  1  upstream sample pair valid.
REQ-007 SHALL have port snk_ready  out  1  feeder accepts the pair this cycle.
REQ-008 SHALL have port snk_left  in  32  left sample.
REQ-009 SHALL have port snk_right  in  32  right sample.
REQ-010 SHALL have port av_address  out  2  audio core register address.
REQ-011 SHALL have port av_chipselect  out  1  audio core select.
REQ-012 SHALL have port av_read  out  1  register read strobe.
REQ-013 SHALL have port av_write  out  1  register write strobe.
REQ-014 SHALL have port av_writedata  out  32  write data.
REQ-015 SHALL have port av_readdata  in  32  read data, valid exactly one cycle after av_read.
REQ-016 SHALL have port fifo_level  out  $clog2(FIFO_DEPTH)+1  pairs currently buffered.
REQ-017 SHALL have port underrun_cnt  out  16  saturating underrun count.

Function
REQ-018 SHALL accept a pair when snk_valid && snk_ready; snk_ready = !full, with no combinational path from snk_valid.
REQ-019 SHALL buffer pairs in order; simultaneous push and pop leave fifo_level unchanged; full blocks push only; empty blocks pop only.
REQ-020 SHALL use states IDLE, POLL_RD, POLL_WAIT, WR_L, WR_R, GAP.
REQ-021 IDLE -> POLL_RD when enable && fifo_level != 0; otherwise it remains in IDLE.
REQ-022 POLL_RD SHALL drive av_chipselect=1, av_read=1, av_address=1 for exactly one cycle, then -> POLL_WAIT.
REQ-023 POLL_WAIT SHALL capture credit = min(av_readdata[31:24], av_readdata[23:16]) (8-bit unsigned).
  - credit==0 -> GAP.
  - otherwise -> WR_L.
REQ-024 WR_L SHALL drive av_chipselect=1, av_write=1, av_address=2, av_writedata=head left for one cycle, then -> WR_R.
REQ-025 WR_R SHALL drive av_address=3, av_writedata=head right, pop the FIFO, and decrement credit.
  - -> WR_L if enable && new credit != 0 && FIFO non-empty after the pop.
  - otherwise -> IDLE.
REQ-026 A started pair SHALL always complete: WR_L is always followed by WR_R, regardless of enable.
REQ-027 GAP SHALL wait POLL_GAP cycles, then -> IDLE.
REQ-028 All av_* strobes SHALL be registered and 0 in every state not listed above.
  - av_read and av_write are never both 1.
  - av_writedata and av_address are don't-care when no strobe is asserted.
REQ-029 underrun_cnt SHALL increment by 1, saturating at 0xFFFF, on each cycle the FSM leaves WR_R with credit != 0 and the FIFO empty.
REQ-030 Latency from the first accepted pair (FIFO empty, IDLE, enable=1) to av_write on the left channel SHALL be 4 cycles when credit > 0.

Reset
REQ-031 On reset_n=0, SHALL immediately reach the following, mid-transaction included:
  - state IDLE, FIFO empty, credit=0, underrun_cnt=0;
  - av_chipselect, av_read, av_write = 0; av_address=0; av_writedata=0;
  - snk_ready=0, fifo_level=0.
REQ-032 snk_ready SHALL rise on the first clk edge after reset_n deasserts.

Structure
REQ-033 Shared package audio_pkg SHALL hold the following, reused by sibling audio blocks:
  - register addresses: CTRL=0, FIFOSPACE=1, LEFTDATA=2, RIGHTDATA=3;
  - FIFOSPACE field bit positions;
  - FSM state enum.
REQ-034 FIFO storage SHALL be a sub-module audio_sample_fifo (64-bit wide, FIFO_DEPTH deep, synchronous, registered count).

Verification
REQ-035 Bench SHALL check: 3 pairs pushed, readdata=0x0202_0000 -> writes L0,R0,L1,R1 at addresses 2,3,2,3, then IDLE with fifo_level=1.
REQ-036 Bench SHALL check: readdata=0x0000_0000 -> no writes, next av_read exactly POLL_GAP+2 cycles after POLL_WAIT.
REQ-037 Bench SHALL check: push 16 pairs with enable=0 -> snk_ready=0, fifo_level=16, 17th pair not accepted.
REQ-038 Bench SHALL check: enable dropped during WR_L -> WR_R still issued, then IDLE, no further strobes.
REQ-039 Bench SHALL check: 1 pair, readdata=0x4040_0000 -> one pair written, underrun_cnt=1.
REQ-040 Bench SHALL check: reset_n pulsed during WR_L -> av_write=0 in the same cycle, fifo_level=0, underrun_cnt=0.
